adc_frame_align_ctrl: RTL and testbench

Frame-alignment controller for one AD9228 LVDS lane group. It sits between the 1:8 deserializer and the 12-bit gearbox. It watches the deserialized FCO byte stream, issues bitslip pulses to the deserializer until FCO matches the expected 12-bit frame pattern, then releases the gearbox from reset. It also marks frame boundaries and re-aligns automatically on sustained loss of lock.

---
 rtl/adc_align_pkg.sv | 37 +++
 rtl/adc_frame_align_ctrl_if.sv | 22 ++
 rtl/adc_fco_seq_tracker.sv | 53 +++++
 rtl/adc_frame_align_ctrl.sv | 142 ++++++++++++++
 tb/tb_adc_frame_align_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_align_pkg.sv
// Shared types and constants for the AD9228 FCO frame-alignment controller.
// The FCO pattern repeats every 24 bits (two 12-bit frames) as three bytes.
package adc_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } align_state_t;

    localparam logic [7:0] FCO_SEQ0 = 8'hFC;
    localparam logic [7:0] FCO_SEQ1 = 8'h0F;
    localparam logic [7:0] FCO_SEQ2 = 8'hC0;

    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int MATCH_COUNT_DEF   = 32;
    localparam int MAX_SLIPS_DEF     = 8;
    localparam int ERR_LIMIT_DEF     = 4;

    typedef logic [1:0] fco_phase_t;

    function automatic logic [7:0] phase_byte(input fco_phase_t p);
        case (p)
            2'd0:    return FCO_SEQ0;
            2'd1:    return FCO_SEQ1;
            default: return FCO_SEQ2;
        endcase
    endfunction

    function automatic fco_phase_t next_phase(input fco_phase_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/adc_frame_align_ctrl_if.sv
// Byte-stream and control bundle between the deserializer side and the aligner.
interface adc_frame_align_ctrl_if;
    logic       start;
    logic [7:0] fco_byte;
    logic       fco_valid;
    logic       bitslip;
    logic       gearbox_rstn;
    logic       frame_start;
    logic       aligned;
    logic       align_fail;
    logic [2:0] slip_count;

    modport master (
        output start, fco_byte, fco_valid,
        input  bitslip, gearbox_rstn, frame_start, aligned, align_fail, slip_count
    );

    modport slave (
        input  start, fco_byte, fco_valid,
        output bitslip, gearbox_rstn, frame_start, aligned, align_fail, slip_count
    );
endinterface

// File: rtl/adc_fco_seq_tracker.sv
// Tracks the expected FCO byte phase and classifies each valid byte as good or bad.
// The first byte after acquire only needs to be some SEQx; it then fixes the phase.
module adc_fco_seq_tracker
    import adc_align_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       acquire,
    input  logic [7:0] fco_byte,
    input  logic       fco_valid,
    output logic       good,
    output logic       bad,
    output logic       is_seq0
);

    logic       known_q;
    fco_phase_t exp_q;
    logic       hit0, hit1, hit2, in_seq;
    fco_phase_t acq_next;

    always_comb begin
        hit0     = (fco_byte == FCO_SEQ0);
        hit1     = (fco_byte == FCO_SEQ1);
        hit2     = (fco_byte == FCO_SEQ2);
        acq_next = 2'd0;
        if (hit0)
            acq_next = 2'd1;
        else if (hit1)
            acq_next = 2'd2;
        in_seq   = known_q ? (fco_byte == phase_byte(exp_q)) : (hit0 | hit1 | hit2);
        good     = fco_valid && in_seq;
        bad      = fco_valid && !in_seq;
        is_seq0  = good && hit0;
    end

    // acquire wins over the update so the byte that ends a lock leaves the phase unknown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            known_q <= 1'b0;
            exp_q   <= 2'd0;
        end else if (acquire) begin
            known_q <= 1'b0;
        end else if (fco_valid) begin
            if (known_q) begin
                exp_q <= next_phase(exp_q);
            end else if (hit0 | hit1 | hit2) begin
                known_q <= 1'b1;
                exp_q   <= acq_next;
            end
        end
    end

endmodule

// File: rtl/adc_frame_align_ctrl.sv
// FCO frame-alignment controller: bitslips the deserializer until the FCO byte
// stream is in sequence, then releases the gearbox and flags frame starts.
module adc_frame_align_ctrl
    import adc_align_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MATCH_COUNT   = MATCH_COUNT_DEF,
    parameter int MAX_SLIPS     = MAX_SLIPS_DEF,
    parameter int ERR_LIMIT     = ERR_LIMIT_DEF
) (
    input  logic                   data_in_clk,
    input  logic                   rst,
    adc_frame_align_ctrl_if.slave  bus
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int MC_W = $clog2(MATCH_COUNT + 1);
    localparam int SD_W = $clog2(MAX_SLIPS + 1);
    localparam int ER_W = $clog2(ERR_LIMIT + 1);

    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [MC_W-1:0] MATCH_LAST  = MC_W'(MATCH_COUNT - 1);
    localparam logic [SD_W-1:0] SLIPS_MAX   = SD_W'(MAX_SLIPS);
    localparam logic [ER_W-1:0] ERR_LAST    = ER_W'(ERR_LIMIT - 1);

    align_state_t    state_q;
    logic [SC_W-1:0] settle_cnt_q;
    logic [MC_W-1:0] match_cnt_q;
    logic [SD_W-1:0] slips_done_q;
    logic [ER_W-1:0] err_run_q;
    logic [2:0]      slip_count_q;
    logic            bitslip_q, gearbox_rstn_q, frame_start_q, aligned_q, align_fail_q;

    logic trk_good, trk_bad, trk_is_seq0, err_exit, acquire;

    assign err_exit = (state_q == LOCKED) && trk_bad && (err_run_q == ERR_LAST);
    assign acquire  = bus.start || err_exit || ((state_q != CHECK) && (state_q != LOCKED));

    adc_fco_seq_tracker u_tracker (
        .clk       (data_in_clk),
        .rst       (rst),
        .acquire   (acquire),
        .fco_byte  (bus.fco_byte),
        .fco_valid (bus.fco_valid),
        .good      (trk_good),
        .bad       (trk_bad),
        .is_seq0   (trk_is_seq0)
    );

    // start outranks every state-local event; slip_count deliberately survives it
    always_ff @(posedge data_in_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            settle_cnt_q   <= '0;
            match_cnt_q    <= '0;
            slips_done_q   <= '0;
            err_run_q      <= '0;
            slip_count_q   <= '0;
            bitslip_q      <= 1'b0;
            gearbox_rstn_q <= 1'b0;
            frame_start_q  <= 1'b0;
            aligned_q      <= 1'b0;
            align_fail_q   <= 1'b0;
        end else begin
            bitslip_q     <= 1'b0;
            frame_start_q <= 1'b0;
            if (bus.start) begin
                state_q        <= SETTLE;
                settle_cnt_q   <= '0;
                match_cnt_q    <= '0;
                slips_done_q   <= '0;
                err_run_q      <= '0;
                align_fail_q   <= 1'b0;
                aligned_q      <= 1'b0;
                gearbox_rstn_q <= 1'b0;
            end else begin
                case (state_q)
                    SETTLE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q     <= CHECK;
                            match_cnt_q <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (trk_good) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                state_q        <= LOCKED;
                                aligned_q      <= 1'b1;
                                gearbox_rstn_q <= 1'b1;
                                err_run_q      <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                            end
                        end else if (trk_bad) begin
                            if (slips_done_q == SLIPS_MAX) begin
                                state_q      <= FAIL;
                                align_fail_q <= 1'b1;
                            end else begin
                                state_q      <= SLIP;
                                bitslip_q    <= 1'b1;
                                slip_count_q <= slip_count_q + 1'b1;
                                slips_done_q <= slips_done_q + 1'b1;
                            end
                        end
                    end
                    SLIP: begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= '0;
                    end
                    LOCKED: begin
                        if (trk_good) begin
                            err_run_q     <= '0;
                            frame_start_q <= trk_is_seq0;
                        end else if (err_exit) begin
                            state_q        <= CHECK;
                            slips_done_q   <= '0;
                            match_cnt_q    <= '0;
                            err_run_q      <= '0;
                            aligned_q      <= 1'b0;
                            gearbox_rstn_q <= 1'b0;
                        end else if (trk_bad) begin
                            err_run_q <= err_run_q + 1'b1;
                        end
                    end
                    IDLE, FAIL: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.bitslip      = bitslip_q;
    assign bus.gearbox_rstn = gearbox_rstn_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.aligned      = aligned_q;
    assign bus.align_fail   = align_fail_q;
    assign bus.slip_count   = slip_count_q;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Directed bench for adc_frame_align_ctrl with a bit-rotating deserializer model.
module tb_adc_frame_align_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] pat = 24'hFC0FC0;
    int          rot = 0;
    int          idx = 0;
    logic [7:0]  lastByte = 8'h00;

    adc_frame_align_ctrl_if bus();

    adc_frame_align_ctrl dut (
        .data_in_clk (clk),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Byte i of the 24-bit pattern after rotating the bit stream left by r bits
    function automatic logic [7:0] streamByte(input int r, input int i);
        logic [47:0] dbl;
        logic [23:0] word;
        dbl  = {pat, pat};
        word = dbl[47-r -: 24];
        return word[23-8*i -: 8];
    endfunction

    task automatic applyStimulus(input logic s, input logic useStream, input logic [7:0] forced);
        logic [7:0] b;
        b = useStream ? streamByte(rot, idx) : forced;
        idx = (idx + 1) % 3;
        bus.fco_byte  = b;
        bus.fco_valid = 1'b1;
        bus.start     = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lastByte  = b;
        if (bus.bitslip === 1'b1) rot = (rot == 0) ? 23 : rot - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.fco_valid = 1'b0;
        bus.fco_byte = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus.bitslip !== 1'b0) begin errors++; $display("[TB] FAIL reset_bitslip got %b want 0", bus.bitslip); end
        checks++; if (bus.gearbox_rstn !== 1'b0) begin errors++; $display("[TB] FAIL reset_gearbox_rstn got %b want 0", bus.gearbox_rstn); end
        checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got %b want 0", bus.frame_start); end
        checks++; if (bus.aligned !== 1'b0) begin errors++; $display("[TB] FAIL reset_aligned got %b want 0", bus.aligned); end
        checks++; if (bus.align_fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_align_fail got %b want 0", bus.align_fail); end
        checks++; if (bus.slip_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_slip_count got %0d want 0", bus.slip_count); end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        int slips = 0;
        int fs = 0;
        rot = 0;
        idx = 0;
        applyStimulus(1'b1, 1'b1, 8'h00);
        for (int i = 1; i <= 48; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            if (bus.bitslip === 1'b1) slips++;
            if (i == 47) begin
                checks++; if (bus.aligned !== 1'b0) begin errors++; $display("[TB] FAIL clean_aligned_early got %b want 0", bus.aligned); end
            end
            if (i == 48) begin
                checks++; if (bus.aligned !== 1'b1) begin errors++; $display("[TB] FAIL clean_aligned got %b want 1", bus.aligned); end
                checks++; if (bus.gearbox_rstn !== 1'b1) begin errors++; $display("[TB] FAIL clean_gearbox_rstn got %b want 1", bus.gearbox_rstn); end
            end
        end
        checks++; if (slips != 0) begin errors++; $display("[TB] FAIL clean_no_bitslip got %0d want 0", slips); end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.frame_start !== (lastByte == 8'hFC)) begin
                errors++; $display("[TB] FAIL clean_frame_start byte %h got %b want %b", lastByte, bus.frame_start, lastByte == 8'hFC);
            end
            if (bus.frame_start === 1'b1) fs++;
        end
        checks++; if (fs != 3) begin errors++; $display("[TB] FAIL clean_frame_start_count got %0d want 3", fs); end
    endtask

    task automatic test_lock_loss();
        int slips = 0;
        int fsUnaligned = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h55);
            checks++;
            if ({bus.aligned, bus.frame_start} !== 2'b10) begin
                errors++; $display("[TB] FAIL loss3_hold got aligned %b frame_start %b want 1 0", bus.aligned, bus.frame_start);
            end
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checks++;
            if ({bus.aligned, bus.frame_start} !== {1'b1, lastByte == 8'hFC}) begin
                errors++; $display("[TB] FAIL loss3_recover got aligned %b frame_start %b want 1 %b", bus.aligned, bus.frame_start, lastByte == 8'hFC);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h55);
            if (i == 3) begin
                checks++; if (bus.aligned !== 1'b1) begin errors++; $display("[TB] FAIL loss4_third got %b want 1", bus.aligned); end
            end
            if (i == 4) begin
                checks++;
                if ({bus.aligned, bus.gearbox_rstn} !== 2'b00) begin
                    errors++; $display("[TB] FAIL loss4_drop got aligned %b gearbox_rstn %b want 0 0", bus.aligned, bus.gearbox_rstn);
                end
            end
        end
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            if (bus.bitslip === 1'b1) slips++;
            if (bus.aligned !== 1'b1 && bus.frame_start === 1'b1) fsUnaligned++;
            if (i == 31) begin
                checks++; if (bus.aligned !== 1'b0) begin errors++; $display("[TB] FAIL relock_early got %b want 0", bus.aligned); end
            end
            if (i == 32) begin
                checks++;
                if ({bus.aligned, bus.gearbox_rstn} !== 2'b11) begin
                    errors++; $display("[TB] FAIL relock got aligned %b gearbox_rstn %b want 1 1", bus.aligned, bus.gearbox_rstn);
                end
            end
        end
        checks++; if (slips != 0) begin errors++; $display("[TB] FAIL relock_no_bitslip got %0d want 0", slips); end
        checks++; if (fsUnaligned != 0) begin errors++; $display("[TB] FAIL frame_start_unaligned got %0d want 0", fsUnaligned); end
    endtask

    task automatic test_shifted();
        int st[3] = '{-1, -1, -1};
        int n = 0;
        rot = 3;
        applyStimulus(1'b1, 1'b1, 8'h00);
        checks++;
        if ({bus.aligned, bus.gearbox_rstn} !== 2'b00) begin
            errors++; $display("[TB] FAIL start_in_locked got aligned %b gearbox_rstn %b want 0 0", bus.aligned, bus.gearbox_rstn);
        end
        for (int i = 1; i <= 102; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            if (bus.bitslip === 1'b1) begin
                if (n < 3) st[n] = i;
                n++;
            end
            if (i == 101) begin
                checks++; if (bus.aligned !== 1'b0) begin errors++; $display("[TB] FAIL shifted_aligned_early got %b want 0", bus.aligned); end
            end
            if (i == 102) begin
                checks++; if (bus.aligned !== 1'b1) begin errors++; $display("[TB] FAIL shifted_aligned got %b want 1", bus.aligned); end
            end
        end
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL shifted_slip_pulses got %0d want 3", n); end
        checks++;
        if (st[0] != 17 || st[1] != 35 || st[2] != 53) begin
            errors++; $display("[TB] FAIL shifted_slip_times got %0d %0d %0d want 17 35 53", st[0], st[1], st[2]);
        end
        checks++; if (bus.slip_count !== 3'd3) begin errors++; $display("[TB] FAIL shifted_slip_count got %0d want 3", bus.slip_count); end
    endtask

    task automatic test_never_valid();
        int n = 0;
        int lastSlip = -1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hAA);
        for (int i = 1; i <= 161; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA);
            if (bus.bitslip === 1'b1) begin n++; lastSlip = i; end
            if (i == 160) begin
                checks++; if (bus.align_fail !== 1'b0) begin errors++; $display("[TB] FAIL fail_early got %b want 0", bus.align_fail); end
            end
            if (i == 161) begin
                checks++;
                if ({bus.align_fail, bus.aligned} !== 2'b10) begin
                    errors++; $display("[TB] FAIL fail_rise got align_fail %b aligned %b want 1 0", bus.align_fail, bus.aligned);
                end
            end
        end
        checks++; if (n != 8) begin errors++; $display("[TB] FAIL fail_slip_pulses got %0d want 8", n); end
        checks++; if (lastSlip != 143) begin errors++; $display("[TB] FAIL fail_last_slip got %0d want 143", lastSlip); end
        checks++; if (bus.slip_count !== 3'd0) begin errors++; $display("[TB] FAIL fail_slip_wrap got %0d want 0", bus.slip_count); end
        applyStimulus(1'b1, 1'b0, 8'hAA);
        checks++; if (bus.align_fail !== 1'b0) begin errors++; $display("[TB] FAIL fail_cleared got %b want 0", bus.align_fail); end
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA);
            if (i == 16) begin
                checks++; if (bus.bitslip !== 1'b0) begin errors++; $display("[TB] FAIL restart_settle got %b want 0", bus.bitslip); end
            end
            if (i == 17) begin
                checks++;
                if ({bus.bitslip, bus.slip_count} !== {1'b1, 3'd1}) begin
                    errors++; $display("[TB] FAIL restart_slip got bitslip %b slip_count %0d want 1 1", bus.bitslip, bus.slip_count);
                end
            end
        end
    endtask

    task automatic test_priority();
        int slips = 0;
        applyStimulus(1'b1, 1'b0, 8'hAA);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA);
            if (bus.bitslip === 1'b1) slips++;
        end
        applyStimulus(1'b1, 1'b0, 8'hAA);
        checks++;
        if ({bus.bitslip, bus.slip_count} !== {1'b0, 3'd1}) begin
            errors++; $display("[TB] FAIL prio_start_vs_bad got bitslip %b slip_count %0d want 0 1", bus.bitslip, bus.slip_count);
        end
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA);
            if (i <= 16 && bus.bitslip === 1'b1) slips++;
            if (i == 17) begin
                checks++;
                if ({bus.bitslip, bus.slip_count} !== {1'b1, 3'd2}) begin
                    errors++; $display("[TB] FAIL prio_resettle_slip got bitslip %b slip_count %0d want 1 2", bus.bitslip, bus.slip_count);
                end
            end
        end
        checks++; if (slips != 0) begin errors++; $display("[TB] FAIL prio_early_slips got %0d want 0", slips); end
    endtask

    task automatic test_reset_mid_slip();
        int slips = 0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.bitslip !== 1'b0) begin errors++; $display("[TB] FAIL midslip_bitslip got %b want 0", bus.bitslip); end
        checks++; if (bus.slip_count !== 3'd0) begin errors++; $display("[TB] FAIL midslip_slip_count got %0d want 0", bus.slip_count); end
        checks++;
        if ({bus.gearbox_rstn, bus.frame_start, bus.aligned, bus.align_fail} !== 4'b0000) begin
            errors++; $display("[TB] FAIL midslip_flags got %b want 0000", {bus.gearbox_rstn, bus.frame_start, bus.aligned, bus.align_fail});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA);
            if (bus.bitslip === 1'b1) slips++;
        end
        checks++; if (slips != 0) begin errors++; $display("[TB] FAIL midslip_idle got %0d slips want 0", slips); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_lock_loss();
        test_shifted();
        test_never_valid();
        test_priority();
        test_reset_mid_slip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
